popcount20_weight_gen: RTL

- Sequential stimulus source for the 20-input approximate popcount circuits; the driving end of their input interface.
- Given a requested Hamming weight k, it enumerates every N-bit input vector with exactly k ones, in ascending numeric order.
- Each vector is emitted over a valid/ready stream together with its exact popcount. The characterisation harness compares this against the approximate circuit output to accumulate MAE/WCE/EP per weight class.

---
 rtl/popcount20_weight_gen_pkg.sv | 27 ++
 rtl/popcount20_weight_gen_if.sv | 26 ++
 rtl/popcount20_weight_gen_next_comb.sv | 34 +++
 rtl/popcount20_weight_gen.sv | 72 +++++++
 4 files changed

// File: rtl/popcount20_weight_gen_pkg.sv
// Shared constants, state type and mask helpers for the fixed-weight vector generator.
package popcount_gen_pkg;

    localparam int N  = 20;
    localparam int CW = 5;
    localparam int IW = 18;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Lowest-valued vector of weight k: bits k-1 .. 0 set.
    function automatic logic [N-1:0] low_mask(input logic [CW-1:0] k);
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = (i < int'(k));
        return m;
    endfunction

    // Highest-valued vector of weight k: bits N-1 .. N-k set.
    function automatic logic [N-1:0] top_mask(input logic [CW-1:0] k);
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = (i >= N - int'(k));
        return m;
    endfunction

endpackage

// File: rtl/popcount20_weight_gen_if.sv
// Start/weight request and valid/ready vector stream of the weight generator.
interface popcount20_weight_gen_if;
    import popcount_gen_pkg::*;

    logic          start;
    logic [CW-1:0] weight;
    logic          busy;
    logic          err;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_vec;
    logic [CW-1:0] out_count;
    logic [IW-1:0] out_idx;
    logic          out_last;

    modport master (
        input  start, weight, out_ready,
        output busy, err, out_valid, out_vec, out_count, out_idx, out_last
    );

    modport slave (
        output start, weight, out_ready,
        input  busy, err, out_valid, out_vec, out_count, out_idx, out_last
    );

endinterface

// File: rtl/popcount20_weight_gen_next_comb.sv
// Gosper step: next larger N-bit vector with the same number of set bits.
module popcount_next_comb
    import popcount_gen_pkg::*;
(
    input  logic [N-1:0] vec_i,
    output logic [N-1:0] vec_o
);

    logic [N:0]    x;
    logic [N:0]    lsb;
    logic [N:0]    sum;
    logic [N:0]    tail;
    logic [N:0]    full;
    logic [CW-1:0] ctz;
    logic [CW:0]   sh;

    always_comb begin
        ctz = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) ctz = CW'(i);
        end
    end

    assign x    = {1'b0, vec_i};
    assign lsb  = x & (~x + {{N{1'b0}}, 1'b1});
    assign sum  = x + lsb;
    assign sh   = {1'b0, ctz} + (CW+1)'(2);
    assign tail = (x ^ sum) >> sh;
    assign full = sum | tail;

    // Stepping past the top combination carries out of N bits; report it as all-zero.
    assign vec_o = full[N] ? '0 : full[N-1:0];

endmodule

// File: rtl/popcount20_weight_gen.sv
// Enumerates all N-bit vectors of a requested weight in ascending order over valid/ready.
module popcount20_weight_gen
    import popcount_gen_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    popcount20_weight_gen_if.master   bus
);

    state_e        state_q;
    logic [CW-1:0] k_q;
    logic [N-1:0]  vec_q;
    logic [N-1:0]  vec_d;
    logic [IW-1:0] idx_q;
    logic          last_q;
    logic          err_q;

    popcount_next_comb u_next (
        .vec_i (vec_q),
        .vec_o (vec_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            vec_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.weight > CW'(N)) begin
                            err_q <= 1'b1;
                        end else begin
                            k_q     <= bus.weight;
                            vec_q   <= low_mask(bus.weight);
                            idx_q   <= '0;
                            last_q  <= (low_mask(bus.weight) == top_mask(bus.weight));
                            state_q <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (last_q) begin
                            last_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            vec_q  <= vec_d;
                            idx_q  <= idx_q + IW'(1);
                            last_q <= (vec_d == top_mask(k_q));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = (state_q == EMIT);
    assign bus.busy      = (state_q == EMIT);
    assign bus.err       = err_q;
    assign bus.out_vec   = vec_q;
    assign bus.out_count = k_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;

endmodule
